fpmul_pipelined: RTL and testbench

FPMUL_PIPELINED -- requirements
Module: fpmul_pipelined

---
 rtl/fpmul_pipelined.sv | 202 ++++++++++++++++++++
 tb/tb_fpmul_pipelined.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_pipelined.sv
// Three-stage pipelined IEEE-754-format multiplier (decode / multiply / round+pack), round-to-nearest-even.
// Defining FPMUL_FLAGS_EN adds the {invalid, overflow, underflow, inexact} flags port and its pipeline.
module fpmul_pipelined #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0]     EXP_MAX = '1;
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_S  = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

  logic advance;
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;

  // Stage 1: unpack and classify
  logic                 sign1_d, sign1_q;
  cls_e                 cls1_d, cls1_q;
  logic [EXP_W-1:0]     ea1_d, ea1_q, eb1_d, eb1_q;
  logic [SW-1:0]        ma1_d, ma1_q, mb1_d, mb1_q;
  logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, inf_x_zero;

  // Stage 2: significand product and biased exponent sum
  logic                 sign2_d, sign2_q;
  cls_e                 cls2_d, cls2_q;
  logic [PW-1:0]        prod2_d, prod2_q;
  logic signed [XW-1:0] exp2_d, exp2_q;

  // Stage 3: normalise, round, pack
  logic [PW-2:0]        norm;
  logic signed [XW-1:0] exp_n, exp_f;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       frac_r;
  logic                 guard, rnd, sticky, round_up, unf, ovf;
  logic [W-1:0]         product_d, product_q;

`ifdef FPMUL_FLAGS_EN
  logic       inv1_d, inv1_q, inv2_d, inv2_q;
  logic [3:0] flags_d, flags_q;
`endif

  // A single global enable: every stage moves when the output slot frees up.
  assign advance = out_ready || !v3_q;
  assign v1_d    = advance ? in_valid : v1_q;
  assign v2_d    = advance ? v1_q     : v2_q;
  assign v3_d    = advance ? v2_q     : v3_q;

  // NOTE: every always_comb variable is assigned a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ea1_d      = a[W-2:MAN_W];
    eb1_d      = b[W-2:MAN_W];
    ma1_d      = {1'b1, a[MAN_W-1:0]};
    mb1_d      = {1'b1, b[MAN_W-1:0]};
    sign1_d    = a[W-1] ^ b[W-1];
    a_zero     = (ea1_d == '0);
    b_zero     = (eb1_d == '0);
    a_inf      = (ea1_d == EXP_MAX) && (a[MAN_W-1:0] == '0);
    b_inf      = (eb1_d == EXP_MAX) && (b[MAN_W-1:0] == '0);
    a_nan      = (ea1_d == EXP_MAX) && (a[MAN_W-1:0] != '0);
    b_nan      = (eb1_d == EXP_MAX) && (b[MAN_W-1:0] != '0);
    inf_x_zero = (a_inf && b_zero) || (b_inf && a_zero);
    cls1_d     = CLS_NUM;
    if (a_nan || b_nan || inf_x_zero) cls1_d = CLS_NAN;
    else if (a_inf || b_inf)          cls1_d = CLS_INF;
    else if (a_zero || b_zero)        cls1_d = CLS_ZERO;
`ifdef FPMUL_FLAGS_EN
    inv1_d = (a_nan && !a[MAN_W-1]) || (b_nan && !b[MAN_W-1]) || inf_x_zero;
`endif
  end

  always_comb begin
    sign2_d = sign1_q;
    cls2_d  = cls1_q;
    prod2_d = PW'(ma1_q) * PW'(mb1_q);
    exp2_d  = XW'(ea1_q) + XW'(eb1_q) - BIAS;
`ifdef FPMUL_FLAGS_EN
    inv2_d  = inv1_q;
`endif
  end

  always_comb begin
    norm      = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
    exp_n     = exp2_q + XW'(prod2_q[PW-1]);
    frac      = norm[PW-2 -: MAN_W];
    guard     = norm[PW-2-MAN_W];
    rnd       = norm[PW-3-MAN_W];
    sticky    = |norm[PW-4-MAN_W:0];
    round_up  = guard && (rnd || sticky || frac[0]);
    frac_r    = {1'b0, frac} + (MAN_W+1)'(round_up);
    // A carry out of the rounded fraction leaves it all-zero, i.e. 1.0 at the next exponent.
    exp_f     = exp_n + XW'(frac_r[MAN_W]);
    unf       = exp_f[XW-1] || (exp_f == '0);
    ovf       = !exp_f[XW-1] && (exp_f >= EMAX_S);
    product_d = {sign2_q, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
`ifdef FPMUL_FLAGS_EN
    flags_d   = {1'b0, 1'b0, 1'b0, guard || rnd || sticky};
`endif
    case (cls2_q)
      CLS_NAN: begin
        product_d = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
        flags_d   = {inv2_q, 3'b000};
`endif
      end
      CLS_INF: begin
        product_d = {sign2_q, EXP_MAX, {MAN_W{1'b0}}};
`ifdef FPMUL_FLAGS_EN
        flags_d   = 4'b0000;
`endif
      end
      CLS_ZERO: begin
        product_d = {sign2_q, {(W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
        flags_d   = 4'b0000;
`endif
      end
      default: begin
        if (unf) begin
          product_d = {sign2_q, {(W-1){1'b0}}};
`ifdef FPMUL_FLAGS_EN
          flags_d   = 4'b0011;
`endif
        end else if (ovf) begin
          product_d = {sign2_q, EXP_MAX, {MAN_W{1'b0}}};
`ifdef FPMUL_FLAGS_EN
          flags_d   = 4'b0101;
`endif
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      product_q <= '0;
`ifdef FPMUL_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (advance) begin
        product_q <= product_d;
`ifdef FPMUL_FLAGS_EN
        flags_q   <= flags_d;
`endif
      end
    end
  end

  // NOTE: inner datapath registers are deliberately not reset; the valid bits qualify their contents.
  always_ff @(posedge clock) begin
    if (advance) begin
      sign1_q <= sign1_d;
      cls1_q  <= cls1_d;
      ea1_q   <= ea1_d;
      eb1_q   <= eb1_d;
      ma1_q   <= ma1_d;
      mb1_q   <= mb1_d;
      sign2_q <= sign2_d;
      cls2_q  <= cls2_d;
      prod2_q <= prod2_d;
      exp2_q  <= exp2_d;
`ifdef FPMUL_FLAGS_EN
      inv1_q  <= inv1_d;
      inv2_q  <= inv2_d;
`endif
    end
  end

  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign product   = product_q;
`ifdef FPMUL_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fpmul_pipelined.sv
// Self-checking bench for fpmul_pipelined (binary32): directed vectors, stalled and random streams, mid-flight reset.
// Flag checks are compiled in when FPMUL_FLAGS_EN is defined.
module tb_fpmul_pipelined;

  logic        clock = 1'b0;
  logic        nreset;
  logic [31:0] a, b, product;
  logic        in_valid, in_ready, out_valid, out_ready;
`ifdef FPMUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  int tests  = 0;
  int failed = 0;

  fpmul_pipelined #(.EXP_W(8), .MAN_W(23)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FPMUL_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [3:0]  f;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: exact integer product of the significands, then round-to-nearest-even by remainder comparison.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex = int'(x[30:23]);
    int ey = int'(y[30:23]);
    logic sign = x[31] ^ y[31];
    bit x_zero = (ex == 0);
    bit y_zero = (ey == 0);
    bit x_inf  = (ex == 255) && (x[22:0] == 0);
    bit y_inf  = (ey == 255) && (y[22:0] == 0);
    bit x_nan  = (ex == 255) && (x[22:0] != 0);
    bit y_nan  = (ey == 255) && (y[22:0] != 0);
    bit inf_zero = (x_inf && y_zero) || (y_inf && x_zero);
    bit snan   = (x_nan && !x[22]) || (y_nan && !y[22]);
    longint unsigned p, q, rem, half;
    int e, sh;
    bit nx;
    if (x_nan || y_nan || inf_zero) return {snan || inf_zero, 3'b000, 32'h7FC00000};
    if (x_inf || y_inf)             return {4'b0000, sign, 8'hFF, 23'h0};
    if (x_zero || y_zero)           return {4'b0000, sign, 31'h0};
    p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e < 1)    return {4'b0011, sign, 31'h0};
    if (e >= 255) return {4'b0101, sign, 8'hFF, 23'h0};
    return {3'b000, nx, sign, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v = $urandom;
    int sel = $urandom_range(0, 7);
    if (sel <= 4)      v[30:23] = 8'(100 + $urandom_range(0, 55));
    else if (sel == 5) v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
    else if (sel == 6) v[30:23] = 8'(190 + $urandom_range(0, 64));
    else               v[30:23] = 8'($urandom_range(1, 30));
    return v;
  endfunction

  // One operation through an idle pipeline; lat counts negedges after the accepting edge.
  task automatic send_one(input logic [31:0] xa, input logic [31:0] xb, output int lat);
    @(negedge clock);
    a = xa; b = xb; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic stream(input int n_ops, input bit random_mode, input string tag);
    logic [35:0] exp_q[$];
    logic [35:0] e;
    int sent = 0, got = 0, cyc = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_p = '0;
`ifdef FPMUL_FLAGS_EN
    logic [3:0] prev_f = '0;
`endif
    while ((sent < n_ops || got < sent) && cyc < 5000) begin
      @(negedge clock);
      if (sent < n_ops) begin
        in_valid = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        a = random_mode ? rand_op() : 32'h3F800000 + 32'(sent);
        b = random_mode ? rand_op() : 32'h40000000 + 32'(sent * 3);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = random_mode ? ($urandom_range(0, 2) != 0) : (cyc % 3 == 0);
      #1;
      if (prev_stall) begin
        check({tag, " stall out_valid held"}, 64'(out_valid), 64'd1);
        check({tag, " stall product held"}, 64'(product), 64'(prev_p));
`ifdef FPMUL_FLAGS_EN
        check({tag, " stall flags held"}, 64'(flags), 64'(prev_f));
`endif
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(a, b));
        sent++;
      end
      if (out_valid && out_ready) begin
        check({tag, " output has pending request"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("%s result %0d product", tag, got), 64'(product), 64'(e[31:0]));
`ifdef FPMUL_FLAGS_EN
          check($sformatf("%s result %0d flags", tag, got), 64'(flags), 64'(e[35:32]));
`endif
          got++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = product;
`ifdef FPMUL_FLAGS_EN
      prev_f     = flags;
`endif
      cyc++;
    end
    check({tag, " results delivered"}, 64'(got), 64'(n_ops));
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[$];
    int lat;

    vecs.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101});
    vecs.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001});
    vecs.push_back('{32'h3F800001, 32'h3F800003, 32'h3F800004, 4'b0001});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h00000001, 32'h7F000000, 32'h00000000, 4'b0000});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000});
    vecs.push_back('{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000});
    vecs.push_back('{32'h3FFFF800, 32'h3F800400, 32'h40000000, 4'b0001});
    vecs.push_back('{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001});
    vecs.push_back('{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 4'b0101});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000});

    nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product", 64'(product), 64'd0);
`ifdef FPMUL_FLAGS_EN
    check("reset flags", 64'(flags), 64'd0);
`endif
    @(negedge clock);
    nreset = 1'b1;
    #1;
    check("in_ready after reset release", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      send_one(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
      check($sformatf("vec%0d product", i), 64'(product), 64'(vecs[i].p));
`ifdef FPMUL_FLAGS_EN
      check($sformatf("vec%0d flags", i), 64'(flags), 64'(vecs[i].f));
`endif
    end

    stream(8, 1'b0, "stall8");
    stream(300, 1'b1, "random");

    // Three operations in flight, then an asynchronous reset between edges.
    @(negedge clock);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000 + 32'(i); b = 32'h40400000; in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("pipeline full before reset", 64'(out_valid), 64'd1);
    #2;
    nreset = 1'b0;
    #1;
    check("mid-flight reset out_valid", 64'(out_valid), 64'd0);
    check("mid-flight reset product", 64'(product), 64'd0);
    @(negedge clock);
    nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check($sformatf("no stale result cycle %0d", i), 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
